// File: rtl/sdrc_pkg.sv
// Shared types and address geometry for the BRAM-backed SDRAM controller stand-in.
package sdrc_pkg;

    typedef enum logic [2:0] {
        CmdLoadMode,
        CmdRefresh,
        CmdPrecharge,
        CmdActivate,
        CmdWrite,
        CmdRead,
        CmdNop
    } sdrc_cmd_e;

    localparam int BankBits = 2;
    localparam int RowBits  = 11;
    localparam int ColBits  = 8;
    localparam int AddrBits = BankBits + RowBits + ColBits;
    localparam int NumBanks = 2 ** BankBits;
    localparam int DataBits = 32;
    localparam int MaskBits = DataBits / 8;
    localparam int LenBits  = 8;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StAck,
        StWrite,
        StRead
    } st_e;

endpackage

// File: rtl/sdrc_bram_responder_if.sv
// User-side SDRAM controller bus: the cache drives commands, the responder answers.
interface sdrc_bram_responder_if;

    logic                              I_sdrc_cmd_en;
    logic [2:0]                        I_sdrc_cmd;
    logic                              I_sdrc_precharge_ctrl;
    logic                              I_sdram_power_down;
    logic                              I_sdram_selfrefresh;
    logic [sdrc_pkg::AddrBits-1:0]     I_sdrc_addr;
    logic [sdrc_pkg::MaskBits-1:0]     I_sdrc_dqm;
    logic [sdrc_pkg::DataBits-1:0]     I_sdrc_data;
    logic [sdrc_pkg::LenBits-1:0]      I_sdrc_data_len;
    logic [sdrc_pkg::DataBits-1:0]     O_sdrc_data;
    logic                              O_sdrc_init_done;
    logic                              O_sdrc_cmd_ack;

    modport master (
        output I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_precharge_ctrl, I_sdram_power_down,
               I_sdram_selfrefresh, I_sdrc_addr, I_sdrc_dqm, I_sdrc_data, I_sdrc_data_len,
        input  O_sdrc_data, O_sdrc_init_done, O_sdrc_cmd_ack
    );

    modport slave (
        input  I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_precharge_ctrl, I_sdram_power_down,
               I_sdram_selfrefresh, I_sdrc_addr, I_sdrc_dqm, I_sdrc_data, I_sdrc_data_len,
        output O_sdrc_data, O_sdrc_init_done, O_sdrc_cmd_ack
    );

endinterface

// File: rtl/bram_byte_we.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
module bram_byte_we #(
    parameter int AddrW = 11,
    parameter int DataW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DataW/8-1:0] we,
    input  logic [AddrW-1:0]   waddr,
    input  logic [DataW-1:0]   wdata,
    input  logic               re,
    input  logic [AddrW-1:0]   raddr,
    output logic [DataW-1:0]   rdata
);

    localparam int Bytes = DataW / 8;

    logic [DataW-1:0] mem [2**AddrW];

    // Byte-masked write; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < Bytes; b++) begin
            if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    // Registered read: clears on reset, holds its value while re is low.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sdrc_bram_responder.sv
// BRAM-backed responder mimicking SDRAM controller ack/init/CAS timing for the cache.
module sdrc_bram_responder
    import sdrc_pkg::*;
#(
    parameter int MemAddressBitWidth = 11,
    parameter int InitCycles         = 16,
    parameter int AckLatency         = 2,
    parameter int CasLatency         = 3
) (
    input logic                  clk,
    input logic                  rst,
    sdrc_bram_responder_if.slave bus
);

    // Wide enough for CasLatency plus a 256-word burst.
    localparam int CntW = 12;
    localparam logic [CntW-1:0] InitLast = CntW'(InitCycles - 1);
    localparam logic [CntW-1:0] AckCyc   = CntW'(AckLatency);
    localparam logic [CntW-1:0] RdFirst  = CntW'(CasLatency - 1);
    localparam logic [CntW-1:0] RdEnd    = CntW'(CasLatency);

    st_e                  state, state_nxt;
    logic [CntW-1:0]      cyc;       // cycles since accept (or since reset release in Init)
    logic [CntW-1:0]      len_ext, rd_k;
    logic [BankBits-1:0]  in_bank, bank_q, wbank, rbank;
    logic [RowBits-1:0]   in_row, row_q, wrow, rrow;
    logic [ColBits-1:0]   in_col, col_q, wcol, rcol;
    logic [LenBits-1:0]   len_q;
    logic [RowBits-1:0]   open_row [NumBanks];
    logic [2:0]           in_cmd;
    logic                 accept, wr_first, wr_burst, rd_first, rd_burst, rd_on;
    logic [AddrBits-1:0]  waddr_full, raddr_full;
    logic [MaskBits-1:0]  be;
    logic                 unused;

    assign in_bank = bus.I_sdrc_addr[ColBits+RowBits +: BankBits];
    assign in_row  = bus.I_sdrc_addr[ColBits +: RowBits];
    assign in_col  = bus.I_sdrc_addr[ColBits-1:0];
    assign in_cmd  = bus.I_sdrc_cmd;
    assign accept  = (state == StIdle) && bus.I_sdrc_cmd_en;
    assign len_ext = CntW'(len_q);
    assign rd_k    = cyc - RdFirst;

    // Next-state: Init countdown, dispatch on accept, leave each burst once data and ack are done.
    always_comb begin
        state_nxt = state;
        case (state)
            StInit:  if (cyc == InitLast) state_nxt = StIdle;
            StIdle: begin
                if (bus.I_sdrc_cmd_en) begin
                    if (in_cmd == CmdWrite)     state_nxt = StWrite;
                    else if (in_cmd == CmdRead) state_nxt = StRead;
                    else                        state_nxt = StAck;
                end
            end
            StAck:   if (cyc >= AckCyc) state_nxt = StIdle;
            StWrite: if (cyc >= len_ext && cyc >= AckCyc) state_nxt = StIdle;
            StRead:  if (cyc >= RdEnd + len_ext && cyc >= AckCyc) state_nxt = StIdle;
            default: state_nxt = StInit;
        endcase
    end

    // State register and cycle counter; counter is primed to 1 so it reads k during cycle A+k.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StInit;
            cyc   <= '0;
        end else begin
            state <= state_nxt;
            cyc   <= (state == StIdle) ? CntW'(1) : cyc + CntW'(1);
        end
    end

    // Open row per bank, set by Activate.
    always_ff @(posedge clk) begin
        if (rst) open_row <= '{default: '0};
        else if (accept && in_cmd == CmdActivate) open_row[in_bank] <= in_row;
    end

    // Burst context captured at accept; row resolved from the bank's open row.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_q <= in_bank;
            row_q  <= open_row[in_bank];
            col_q  <= in_col;
            len_q  <= bus.I_sdrc_data_len;
        end
    end

    // Write word 0 comes straight off the bus in the accept cycle; later words use the latched context.
    assign wr_first   = accept && (in_cmd == CmdWrite);
    assign wr_burst   = (state == StWrite) && (cyc <= len_ext);
    assign wbank      = wr_first ? in_bank : bank_q;
    assign wrow       = wr_first ? open_row[in_bank] : row_q;
    assign wcol       = wr_first ? in_col : col_q + cyc[ColBits-1:0];
    assign waddr_full = {wbank, wrow, wcol};
    // Nothing lands in the reset cycle, so an aborted burst keeps only the earlier words.
    assign be         = {MaskBits{(wr_first || wr_burst) && !rst}} & ~bus.I_sdrc_dqm;

    // Reads are issued one cycle ahead of CAS to cover the RAM's registered output.
    // With CasLatency of 1 the first word must be issued from the accept cycle.
    assign rd_first   = accept && (in_cmd == CmdRead) && (CasLatency == 1);
    assign rd_burst   = (state == StRead) && (cyc >= RdFirst) && (rd_k <= len_ext);
    assign rd_on      = rd_first || rd_burst;
    assign rbank      = rd_first ? in_bank : bank_q;
    assign rrow       = rd_first ? open_row[in_bank] : row_q;
    assign rcol       = rd_first ? in_col : col_q + rd_k[ColBits-1:0];
    assign raddr_full = {rbank, rrow, rcol};

    bram_byte_we #(
        .AddrW(MemAddressBitWidth),
        .DataW(DataBits)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (be),
        .waddr (waddr_full[MemAddressBitWidth-1:0]),
        .wdata (bus.I_sdrc_data),
        .re    (rd_on),
        .raddr (raddr_full[MemAddressBitWidth-1:0]),
        .rdata (bus.O_sdrc_data)
    );

    assign bus.O_sdrc_init_done = (state != StInit);
    // Ack is suppressed in a reset cycle so an aborted command never acknowledges.
    assign bus.O_sdrc_cmd_ack   = !rst && (state inside {StAck, StWrite, StRead}) && (cyc == AckCyc);

    assign unused = ^{bus.I_sdrc_precharge_ctrl, bus.I_sdram_power_down, bus.I_sdram_selfrefresh,
                      waddr_full, raddr_full, rd_k};

endmodule

// File: tb/tb_sdrc_bram_responder.sv
// Randomized bench for sdrc_bram_responder against a transaction-level timing/memory model.
module tb_sdrc_bram_responder;
    import sdrc_pkg::*;

    localparam int AW   = 11;
    localparam int INIT = 16;
    localparam int ACKL = 2;
    localparam int CASL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdrc_bram_responder_if bus();

    sdrc_bram_responder #(
        .MemAddressBitWidth(AW),
        .InitCycles        (INIT),
        .AckLatency        (ACKL),
        .CasLatency        (CASL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference state: word array addressed by truncated {bank,row,col}, plus open rows.
    logic [31:0] mdl_mem   [2**AW];
    bit          mdl_known [2**AW];
    logic [10:0] mdl_row   [4];
    logic [31:0] last_data;
    bit          last_known;
    logic [31:0] wdat [256];
    logic [3:0]  wdqm [256];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int midx(input logic [1:0] b, input logic [10:0] r, input logic [7:0] c);
        logic [20:0] f;
        f = {b, r, c};
        return int'(f[AW-1:0]);
    endfunction

    task automatic mdl_write(input int ix, input logic [31:0] d, input logic [3:0] m);
        for (int bt = 0; bt < 4; bt++)
            if (!m[bt]) mdl_mem[ix][bt*8 +: 8] = d[bt*8 +: 8];
        mdl_known[ix] = mdl_known[ix] || (m == 4'h0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_idle();
        bus.I_sdrc_cmd_en         = 1'b0;
        bus.I_sdrc_cmd            = 3'(CmdNop);
        bus.I_sdrc_precharge_ctrl = 1'($urandom);
        bus.I_sdram_power_down    = 1'b0;
        bus.I_sdram_selfrefresh   = 1'b0;
        bus.I_sdrc_addr           = 21'($urandom);
        bus.I_sdrc_dqm            = 4'($urandom);
        bus.I_sdrc_data           = $urandom;
        bus.I_sdrc_data_len       = 8'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drv_idle();
            @(negedge clk);
            chk("idle_ack", 32'(bus.O_sdrc_cmd_ack), 32'd0);
            if (last_known) chk("idle_data", bus.O_sdrc_data, last_data);
            nxt();
        end
    endtask

    // Two reset cycles, then Init: init_done rises exactly INIT cycles after rst falls,
    // with commands offered throughout Init and never acknowledged.
    task automatic do_reset();
        rst = 1'b1;
        drv_idle();
        nxt();
        @(negedge clk);
        chk("rst_init_done", 32'(bus.O_sdrc_init_done), 32'd0);
        chk("rst_ack",       32'(bus.O_sdrc_cmd_ack),   32'd0);
        chk("rst_data",      bus.O_sdrc_data,           32'd0);
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mdl_row[i] = '0;
        last_data  = '0;
        last_known = 1'b1;
        for (int i = 0; i <= INIT; i++) begin
            bus.I_sdrc_cmd_en = (i < INIT);
            bus.I_sdrc_cmd    = 3'(CmdRefresh);
            @(negedge clk);
            chk("init_done", 32'(bus.O_sdrc_init_done), 32'(i == INIT));
            chk("init_ack",  32'(bus.O_sdrc_cmd_ack),   32'd0);
            nxt();
        end
        bus.I_sdrc_cmd_en = 1'b0;
    endtask

    // One command from accept cycle A (k=0) until the responder is expected back in Idle.
    // hold keeps cmd_en high after A; rst_at >= 0 asserts reset at cycle A+rst_at and returns.
    task automatic run_cmd(input logic [2:0] cmd, input logic [1:0] b, input logic [10:0] r,
                           input logic [7:0] c, input int len, input bit hold, input int rst_at);
        int t_end;
        logic [10:0] orow;
        bit is_wr, is_rd;
        is_wr = (cmd == 3'(CmdWrite));
        is_rd = (cmd == 3'(CmdRead));
        orow  = mdl_row[b];
        if (is_wr)      t_end = (len > ACKL) ? len : ACKL;
        else if (is_rd) t_end = CASL + len;
        else            t_end = ACKL;
        for (int k = 0; k <= t_end; k++) begin
            if (k == rst_at) begin
                rst = 1'b1;
                bus.I_sdrc_cmd_en = 1'b0;
                @(negedge clk);
                chk("abort_ack", 32'(bus.O_sdrc_cmd_ack), 32'd0);
                return;
            end
            bus.I_sdrc_cmd_en   = (k == 0) || hold;
            bus.I_sdrc_cmd      = (k == 0) ? cmd : 3'(CmdWrite);
            bus.I_sdrc_addr     = (k == 0) ? {b, r, c} : 21'($urandom);
            bus.I_sdrc_data_len = (k == 0) ? 8'(len) : 8'($urandom);
            bus.I_sdrc_data     = (is_wr && k <= len) ? wdat[k] : $urandom;
            bus.I_sdrc_dqm      = (is_wr && k <= len) ? wdqm[k] : 4'($urandom);
            if (is_wr && k <= len) mdl_write(midx(b, orow, c + 8'(k)), wdat[k], wdqm[k]);
            @(negedge clk);
            chk("ack", 32'(bus.O_sdrc_cmd_ack), 32'(k == ACKL));
            if (is_rd && k >= CASL) begin
                int ix;
                ix = midx(b, orow, c + 8'(k - CASL));
                last_known = mdl_known[ix];
                last_data  = mdl_mem[ix];
                if (last_known) chk("rd_data", bus.O_sdrc_data, last_data);
            end else if (last_known) begin
                chk("data_hold", bus.O_sdrc_data, last_data);
            end
            nxt();
        end
        if (cmd == 3'(CmdActivate)) mdl_row[b] = r;
        bus.I_sdrc_cmd_en = 1'b0;
    endtask

    task automatic fill(input logic [31:0] base, input bit rnd);
        for (int k = 0; k < 256; k++) begin
            wdat[k] = rnd ? $urandom : base + 32'(k);
            wdqm[k] = 4'h0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mdl_mem[i]   = '0;
            mdl_known[i] = 1'b0;
        end
        last_data  = '0;
        last_known = 1'b0;
        drv_idle();
        do_reset();

        // Activate bank1 row5, write 10..13 across the column wrap, read back.
        run_cmd(3'(CmdActivate), 2'd1, 11'd5, 8'd0, 0, 1'b0, -1);
        fill(32'd10, 1'b0);
        run_cmd(3'(CmdWrite), 2'd1, 11'd77, 8'd254, 3, 1'b0, -1);
        run_cmd(3'(CmdRead),  2'd1, 11'd77, 8'd254, 3, 1'b0, -1);

        // Byte mask: 0xAABBCCDD with dqm 0101 over 0x11223344 -> 0xAA22CC44.
        wdat[0] = 32'h1122_3344; wdqm[0] = 4'h0;
        run_cmd(3'(CmdWrite), 2'd1, 11'd0, 8'd10, 0, 1'b0, -1);
        wdat[0] = 32'hAABB_CCDD; wdqm[0] = 4'b0101;
        run_cmd(3'(CmdWrite), 2'd1, 11'd0, 8'd10, 0, 1'b0, -1);
        run_cmd(3'(CmdRead),  2'd1, 11'd0, 8'd10, 0, 1'b0, -1);

        // cmd_en held through a read burst; next command lands on the first Idle cycle.
        run_cmd(3'(CmdRead),  2'd1, 11'd0, 8'd254, 3, 1'b1, -1);
        run_cmd(3'(CmdRead),  2'd1, 11'd0, 8'd254, 3, 1'b0, -1);
        idle_cycles(2);

        // Full 256-word burst on another bank.
        run_cmd(3'(CmdActivate), 2'd2, 11'd3, 8'd0, 0, 1'b0, -1);
        fill(32'd0, 1'b1);
        run_cmd(3'(CmdWrite), 2'd2, 11'd0, 8'd7, 255, 1'b0, -1);
        run_cmd(3'(CmdRead),  2'd2, 11'd0, 8'd7, 255, 1'b0, -1);

        // Reset after word 1 of a 4-word write: words 0-1 new, words 2-3 keep 12,13.
        run_cmd(3'(CmdActivate), 2'd1, 11'd5, 8'd0, 0, 1'b0, -1);
        fill(32'd20, 1'b0);
        run_cmd(3'(CmdWrite), 2'd1, 11'd0, 8'd254, 3, 1'b0, 2);
        do_reset();
        run_cmd(3'(CmdActivate), 2'd1, 11'd5, 8'd0, 0, 1'b0, -1);
        run_cmd(3'(CmdRead),     2'd1, 11'd0, 8'd254, 3, 1'b0, -1);

        // Random mix of every command code, masks, wrap-prone columns and held strobes.
        for (int n = 0; n < 80; n++) begin
            logic [2:0] cmd;
            int sel, len;
            sel = int'($urandom_range(0, 9));
            if (sel < 2)      cmd = 3'(CmdActivate);
            else if (sel < 5) cmd = 3'(CmdWrite);
            else if (sel < 8) cmd = 3'(CmdRead);
            else if (sel < 9) cmd = 3'($urandom_range(0, 2));
            else              cmd = 3'($urandom_range(6, 7));
            len = int'($urandom_range(0, 12));
            for (int k = 0; k < 256; k++) begin
                wdat[k] = $urandom;
                wdqm[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
            run_cmd(cmd, 2'($urandom), 11'($urandom_range(0, 3)), 8'(240 + $urandom_range(0, 31)),
                    len, ($urandom_range(0, 4) == 0), -1);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
